// File: rtl/jt5205_pkg.sv
// rtl/jt5205_pkg.sv - step ROM, index-adjust table and widths shared by encoder and decoder
package jt5205_pkg;

  localparam int PCM_W   = 12;
  localparam int STEP_W  = 11;
  localparam int IDX_W   = 6;
  localparam int IDX_MAX = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DIFF,
    ST_B2,
    ST_B1,
    ST_B0,
    ST_UPD
  } enc_state_t;

  localparam logic signed [4:0] ADJ_LOW = -5'sd1;
  localparam logic signed [4:0] ADJ_4   = 5'sd2;
  localparam logic signed [4:0] ADJ_5   = 5'sd4;
  localparam logic signed [4:0] ADJ_6   = 5'sd6;
  localparam logic signed [4:0] ADJ_7   = 5'sd8;

  function automatic logic signed [4:0] idx_adj(input logic [2:0] mag);
    case (mag)
      3'd4:    return ADJ_4;
      3'd5:    return ADJ_5;
      3'd6:    return ADJ_6;
      3'd7:    return ADJ_7;
      default: return ADJ_LOW;
    endcase
  endfunction

  function automatic logic [STEP_W-1:0] step_rom(input logic [IDX_W-1:0] idx);
    case (idx)
      6'd0:  return 11'd16;   6'd1:  return 11'd17;   6'd2:  return 11'd19;
      6'd3:  return 11'd21;   6'd4:  return 11'd23;   6'd5:  return 11'd25;
      6'd6:  return 11'd28;   6'd7:  return 11'd31;   6'd8:  return 11'd34;
      6'd9:  return 11'd37;   6'd10: return 11'd41;   6'd11: return 11'd45;
      6'd12: return 11'd50;   6'd13: return 11'd55;   6'd14: return 11'd60;
      6'd15: return 11'd66;   6'd16: return 11'd73;   6'd17: return 11'd80;
      6'd18: return 11'd88;   6'd19: return 11'd97;   6'd20: return 11'd107;
      6'd21: return 11'd118;  6'd22: return 11'd130;  6'd23: return 11'd143;
      6'd24: return 11'd157;  6'd25: return 11'd173;  6'd26: return 11'd190;
      6'd27: return 11'd209;  6'd28: return 11'd230;  6'd29: return 11'd253;
      6'd30: return 11'd279;  6'd31: return 11'd307;  6'd32: return 11'd337;
      6'd33: return 11'd371;  6'd34: return 11'd408;  6'd35: return 11'd449;
      6'd36: return 11'd494;  6'd37: return 11'd544;  6'd38: return 11'd598;
      6'd39: return 11'd658;  6'd40: return 11'd724;  6'd41: return 11'd796;
      6'd42: return 11'd876;  6'd43: return 11'd963;  6'd44: return 11'd1060;
      6'd45: return 11'd1166; 6'd46: return 11'd1282; 6'd47: return 11'd1411;
      default: return 11'd1552;
    endcase
  endfunction

endpackage

// File: rtl/jt5205_enc_if.sv
// rtl/jt5205_enc_if.sv - PCM input handshake and nibble output bundle
interface jt5205_enc_if;
  import jt5205_pkg::*;

  logic signed [PCM_W-1:0] pcm;
  logic                    pcm_valid;
  logic                    pcm_ready;
  logic [3:0]              dout;
  logic                    dout_valid;
  logic                    underrun;
  logic                    busy;

  modport master (
    output pcm, pcm_valid,
    input  pcm_ready, dout, dout_valid, underrun, busy
  );

  modport slave (
    input  pcm, pcm_valid,
    output pcm_ready, dout, dout_valid, underrun, busy
  );
endinterface

// File: rtl/jt5205_enc_quant.sv
// rtl/jt5205_enc_quant.sv - predictor/step-index state, step lookup and predictor clamp
module jt5205_enc_quant
  import jt5205_pkg::*;
#(
  parameter bit CLAMP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     upd,
  input  logic                     sign,
  input  logic [2:0]               mag,
  input  logic [12:0]              delta,
  output logic signed [PCM_W-1:0]  pred,
  output logic [STEP_W-1:0]        step
);

  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;
  logic signed [IDX_W+1:0] idx_sum;
  logic signed [4:0]       adj;
  logic signed [12:0]      sum;
  logic signed [PCM_W-1:0] pred_nxt;

  assign step = step_rom(idx);

  always_comb begin
    sum      = sign ? ({pred[PCM_W-1], pred} - delta) : ({pred[PCM_W-1], pred} + delta);
    pred_nxt = sum[PCM_W-1:0];
    // the wrapping variant keeps only the low 12 bits of the 13-bit result
    if (CLAMP) begin
      if (sum > 13'sd2047)
        pred_nxt = 12'sd2047;
      else if (sum < -13'sd2048)
        pred_nxt = -12'sd2048;
    end
  end

  always_comb begin
    adj     = idx_adj(mag);
    idx_sum = $signed({2'b00, idx}) + $signed({{3{adj[4]}}, adj});
    idx_nxt = idx_sum[IDX_W-1:0];
    if (idx_sum[IDX_W+1])
      idx_nxt = '0;
    else if (idx_sum > $signed(8'(IDX_MAX)))
      idx_nxt = 6'(IDX_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pred <= '0;
      idx  <= '0;
    end else if (upd) begin
      pred <= pred_nxt;
      idx  <= idx_nxt;
    end
  end

endmodule

// File: rtl/jt5205_enc.sv
// rtl/jt5205_enc.sv - 4-bit MSM5205-compatible ADPCM encoder: sample buffer, handshake and bit-serial quantiser FSM
module jt5205_enc
  import jt5205_pkg::*;
#(
  parameter bit CLAMP         = 1'b1,
  parameter bit UNDERRUN_ZERO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          strobe,
  jt5205_enc_if.slave   bus
);

  enc_state_t state, state_nxt;

  logic                    full;
  logic                    start;
  logic                    consume;
  logic                    accept;
  logic signed [PCM_W-1:0] entry;
  logic signed [PCM_W-1:0] held;
  logic signed [PCM_W-1:0] cur;
  logic signed [PCM_W-1:0] pred;
  logic [STEP_W-1:0]       step;
  logic [12:0]             step_x1, step_x2, step_x4, step_x8;
  logic [12:0]             diff;
  logic [12:0]             rem;
  logic [12:0]             delta;
  logic                    sgn;
  logic [2:0]              bits;
  logic [3:0]              dout;
  logic                    dout_valid;
  logic                    underrun;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    if (cen) begin
      case (state)
        ST_IDLE: if (strobe) begin
          state_nxt = ST_DIFF;
          start     = 1'b1;
        end
        ST_DIFF: state_nxt = ST_B2;
        ST_B2:   state_nxt = ST_B1;
        ST_B1:   state_nxt = ST_B0;
        ST_B0:   state_nxt = ST_UPD;
        ST_UPD:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // the buffer accepts at clk rate; a consume frees the slot in the same cycle
  assign consume       = start && full;
  assign bus.pcm_ready = !full || consume;
  assign accept        = bus.pcm_valid && bus.pcm_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      full  <= 1'b0;
      entry <= '0;
      held  <= '0;
    end else begin
      if (accept) begin
        entry <= bus.pcm;
        full  <= 1'b1;
      end else if (consume) begin
        full <= 1'b0;
      end
      if (consume)
        held <= entry;
    end
  end

  assign step_x1 = {2'b00, step};
  assign step_x2 = {3'b000, step[STEP_W-1:1]};
  assign step_x4 = {4'b0000, step[STEP_W-1:2]};
  assign step_x8 = {5'b00000, step[STEP_W-1:3]};
  assign diff    = {cur[PCM_W-1], cur} - {pred[PCM_W-1], pred};

  always_ff @(posedge clk) begin
    if (rst) begin
      cur        <= '0;
      rem        <= '0;
      delta      <= '0;
      sgn        <= 1'b0;
      bits       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      underrun   <= 1'b0;
      if (start) begin
        cur      <= full ? entry : (UNDERRUN_ZERO ? '0 : held);
        underrun <= !full;
      end
      if (cen) begin
        case (state)
          ST_DIFF: begin
            sgn   <= diff[12];
            rem   <= diff[12] ? (~diff + 13'd1) : diff;
            delta <= step_x8;
            bits  <= '0;
          end
          ST_B2: if (rem >= step_x1) begin
            bits[2] <= 1'b1;
            rem     <= rem - step_x1;
            delta   <= delta + step_x1;
          end
          ST_B1: if (rem >= step_x2) begin
            bits[1] <= 1'b1;
            rem     <= rem - step_x2;
            delta   <= delta + step_x2;
          end
          ST_B0: if (rem >= step_x4) begin
            bits[0] <= 1'b1;
            delta   <= delta + step_x4;
          end
          ST_UPD: begin
            dout       <= {sgn, bits};
            dout_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  jt5205_enc_quant #(
    .CLAMP (CLAMP)
  ) u_quant (
    .clk   (clk),
    .rst   (rst),
    .upd   (cen && state == ST_UPD),
    .sign  (sgn),
    .mag   (bits),
    .delta (delta),
    .pred  (pred),
    .step  (step)
  );

  assign bus.dout       = dout;
  assign bus.dout_valid = dout_valid;
  assign bus.underrun   = underrun;
  assign bus.busy       = (state != ST_IDLE);

endmodule
